perm_key_sweeper: RTL
=====================

// Module: perm_key_sweeper
// PURPOSE
//   Stage directly upstream of the XOR-index permutation selector (o[j] = i[j ^ k]).
//   On start, registers an N_IN input vector and sweeps key k from k_first to k_last
//   (wrapping mod 2^PERMB), driving the selector's k/i inputs. After each key it waits
//   HOLD settle cycles, captures the selector's N_OUT-bit output, and streams
//   (k, data) pairs out over a valid/ready interface.
// PARAMETERS
//   N_IN   64               selector input width; power of two
//   N_OUT  15               selector output width; N_OUT <= N_IN
//   PERMB  $clog2(N_IN)     key width
//   HOLD   2                extra settle cycles per key before capture (0..255)
// PORTS
//   clock        in   1       single clock; all logic on rising edge
//   reset        in   1       synchronous, active-high
//   start_i      in   1       begin sweep; sampled in IDLE only
//   data_i       in   N_IN    vector to permute; latched on accepted start
//   k_first_i    in   PERMB   first key; latched on accepted start
//   k_last_i     in   PERMB   last key; latched on accepted start
//   perm_k_o     out  PERMB   key to selector
//   perm_i_o     out  N_IN    latched data to selector
//   perm_o_i     in   N_OUT   selector output
//   res_valid_o  out  1       result valid
//   res_ready_i  in   1       downstream ready
//   res_k_o      out  PERMB   key of current result
//   res_data_o   out  N_OUT   captured selector output
//   busy_o       out  1       high outside IDLE
//   done_o       out  1       one-cycle pulse after last result accepted
//   err_o        out  1       sticky self-check mismatch (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0 (perm_k_o, perm_i_o, res_* included).
//   FSM IDLE -> SETTLE -> PRESENT -> (SETTLE | DONE) -> IDLE.
//   IDLE: start_i=1 at edge t -> latch data/k_first/k_last, perm_k_o=k_first, cnt=HOLD,
//     state SETTLE from t+1. start_i in any other state is ignored.
//   SETTLE: cnt decrements each cycle; on edge where cnt==0, capture perm_o_i into
//     res_data_o, res_k_o=perm_k_o, res_valid_o=1, state PRESENT.
//   Latency start edge -> first res_valid_o = HOLD+2 cycles.
//   PRESENT: res_valid_o, res_k_o, res_data_o, perm_k_o held stable while res_ready_i=0.
//     On valid&ready: res_valid_o=0 next cycle; if perm_k_o==k_last -> DONE, else
//     perm_k_o <= perm_k_o+1 (mod 2^PERMB wrap, 2^PERMB-1 -> 0), cnt=HOLD, SETTLE.
//   DONE: one cycle; done_o=1, busy_o=1; then IDLE. Back-to-back start accepted next cycle.
//   Results per sweep = ((k_last - k_first) mod 2^PERMB) + 1; k_first==k_last -> exactly 1.
//   Min gap between results = HOLD+2 cycles; never more than one result outstanding.
//   perm_i_o stays at last latched data after the sweep.
//   Reset mid-sweep: next cycle IDLE, all outputs 0, partial results discarded, no done_o.
// CONFIGURATION
//   `PERM_KEY_SWEEPER_CHECK_EN defined: on each capture compute expected
//     exp[j] = latched_data[PERMB'(j) ^ perm_k_o], j=0..N_OUT-1; mismatch sets err_o
//     the cycle after capture; err_o sticky, cleared only by reset or accepted start.
//   Not defined: no checker logic; err_o tied 0. Port list identical in both builds.
// STRUCTURE
//   Package perm_sweep_pkg: state enum (IDLE, SETTLE, PRESENT, DONE), HOLD counter width
//     constant (8), function perm_expected(data, k) used by checker and bench.
//   Sub-module perm_expect (combinational exp vector), instantiated only under the macro.
// TESTING (N_IN=64, N_OUT=15, HOLD=2)
//   data=64'h0123_4567_89AB_CDEF, k 0..3, ready=1 -> 4 results k=0,1,2,3, first valid
//     4 cycles after start, data==perm_expected, done_o one pulse, err_o=0.
//   k_first=62, k_last=1 -> results k=62,63,0,1 in order, then done_o.
//   ready=0 for 5 cycles on first result -> valid/k/data/perm_k_o stable; no loss or dup.
//   reset during SETTLE of 2nd key -> next cycle busy_o=0, res_valid_o=0, perm_k_o=0;
//     fresh start k 5..5 -> exactly one result k=5.
//   start_i pulsed while busy -> ignored; sweep count and keys unchanged.
//   Macro on: flip perm_o_i[3] at k=2 capture -> err_o=1, sticky to next start; macro
//     off -> err_o=0 throughout.

Source files
------------

// File: rtl/perm_key_sweeper_pkg.sv
// Shared types, constants and the reference XOR-index permutation for the key sweeper.
// Used by the RTL checker (PERM_KEY_SWEEPER_CHECK_EN builds) and by the testbench.
package perm_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      PRESENT = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int CNT_W    = 8;
   localparam int PK_MAX_W = 256;

   // o[j] = i[j ^ k] for j < n_out; bits at and above n_out are zero.
   // n_in must be a power of two no larger than PK_MAX_W.
   function automatic logic [PK_MAX_W-1:0] perm_expected(
      input logic [PK_MAX_W-1:0] data,
      input int unsigned         k,
      input int unsigned         n_in,
      input int unsigned         n_out
   );
      logic [PK_MAX_W-1:0] res;
      logic [7:0]          idx;
      res = '0;
      for (int unsigned j = 0; j < PK_MAX_W; j++) begin
         idx = 8'((j ^ k) & (n_in - 1));
         if (j < n_out) res[j] = data[idx];
      end
      return res;
   endfunction

endpackage

// File: rtl/perm_key_sweeper_expect.sv
// Combinational expected output of the XOR-index selector for the latched vector and key.
// Only instantiated when PERM_KEY_SWEEPER_CHECK_EN is defined.
module perm_expect
   import perm_sweep_pkg::*;
#(
   parameter int N_IN  = 64,
   parameter int N_OUT = 15,
   parameter int PERMB = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]  data,
   input  logic [PERMB-1:0] k,
   output logic [N_OUT-1:0] exp_data
);

   always_comb begin
      exp_data = N_OUT'(perm_expected(PK_MAX_W'(data), 32'(k), N_IN, N_OUT));
   end

endmodule

// File: rtl/perm_key_sweeper.sv
// Sweeps the XOR-index selector key over [k_first, k_last] and streams (k, data) results.
// Optional capture self-check is enabled with `define PERM_KEY_SWEEPER_CHECK_EN.
module perm_key_sweeper
   import perm_sweep_pkg::*;
#(
   parameter int N_IN  = 64,
   parameter int N_OUT = 15,
   parameter int PERMB = $clog2(N_IN),
   parameter int HOLD  = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_i,
   input  logic [N_IN-1:0]  data_i,
   input  logic [PERMB-1:0] k_first_i,
   input  logic [PERMB-1:0] k_last_i,
   output logic [PERMB-1:0] perm_k_o,
   output logic [N_IN-1:0]  perm_i_o,
   input  logic [N_OUT-1:0] perm_o_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [PERMB-1:0] res_k_o,
   output logic [N_OUT-1:0] res_data_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             launch_q;
   logic [N_IN-1:0]  data_q;
   logic [PERMB-1:0] k_last_q;
   logic [PERMB-1:0] perm_k_q;
   logic             res_valid_q;
   logic [PERMB-1:0] res_k_q;
   logic [N_OUT-1:0] res_data_q;

   logic start_acc;
   logic capture;
   logic accept;
   logic last_key;

   // Result handshake: a result transfers on a rising edge where res_valid_o and
   // res_ready_i are both high; while valid is high and ready is low, valid, key and
   // data stay frozen, and valid never drops without a transfer (except on reset).
   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      capture   = 1'b0;
      accept    = 1'b0;
      last_key  = (perm_k_q == k_last_q);
      case (state_q)
         IDLE: begin
            if (start_i) begin
               start_acc = 1'b1;
               state_d   = SETTLE;
            end
         end
         SETTLE: begin
            if (!launch_q && (cnt_q == '0)) begin
               capture = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (res_ready_i) begin
               accept  = 1'b1;
               state_d = last_key ? DONE : SETTLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // The first SETTLE cycle after a key change lets the new key reach the selector;
   // the HOLD counter then adds the extra settle cycles before capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q    <= '0;
         launch_q <= 1'b0;
      end else if (start_acc || (accept && !last_key)) begin
         cnt_q    <= CNT_W'(HOLD);
         launch_q <= 1'b1;
      end else if ((state_q == SETTLE) && !capture) begin
         if (launch_q) launch_q <= 1'b0;
         else          cnt_q    <= cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         data_q   <= '0;
         k_last_q <= '0;
         perm_k_q <= '0;
      end else if (start_acc) begin
         data_q   <= data_i;
         k_last_q <= k_last_i;
         perm_k_q <= k_first_i;
      end else if (accept && !last_key) begin
         perm_k_q <= perm_k_q + PERMB'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         res_valid_q <= 1'b0;
         res_k_q     <= '0;
         res_data_q  <= '0;
      end else if (capture) begin
         res_valid_q <= 1'b1;
         res_k_q     <= perm_k_q;
         res_data_q  <= perm_o_i;
      end else if (accept) begin
         res_valid_q <= 1'b0;
      end
   end

`ifdef PERM_KEY_SWEEPER_CHECK_EN
   logic [N_OUT-1:0] exp_data;
   logic             err_q;

   perm_expect #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT),
      .PERMB (PERMB)
   ) u_expect (
      .data     (data_q),
      .k        (perm_k_q),
      .exp_data (exp_data)
   );

   always_ff @(posedge clock) begin
      if (reset || start_acc)                  err_q <= 1'b0;
      else if (capture && (perm_o_i != exp_data)) err_q <= 1'b1;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign perm_k_o    = perm_k_q;
   assign perm_i_o    = data_q;
   assign res_valid_o = res_valid_q;
   assign res_k_o     = res_k_q;
   assign res_data_o  = res_data_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);

endmodule
